// File: rtl/sb_drain_ctrl.sv
// Owns the single D-cache port: arbitrates pipeline loads against store-buffer
// drains, one transaction at a time, with store anti-starvation and fence/flush.
module sb_drain_ctrl #(
  parameter int unsigned SB_ENTRIES   = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CW           = $clog2(SB_ENTRIES + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_req_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_ready,
  output logic          ld_resp_valid,
  output logic [31:0]   ld_resp_data,
  input  logic          sb_deq_valid,
  input  logic [31:0]   sb_deq_addr,
  input  logic [31:0]   sb_deq_data,
  input  logic [3:0]    sb_deq_wstrb,
  input  logic [CW-1:0] sb_count,
  input  logic          sb_full,
  output logic          sb_deq_req,
  input  logic          drain_all,
  output logic          drain_done,
  input  logic          flush,
  output logic          dc_req_valid,
  output logic          dc_req_we,
  output logic [31:0]   dc_req_addr,
  output logic [31:0]   dc_req_wdata,
  output logic [3:0]    dc_req_wstrb,
  input  logic          dc_req_ready,
  input  logic          dc_resp_valid,
  input  logic [31:0]   dc_resp_rdata
);

  localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    wstrb_q;
  logic          drain_pending_q, kill_q;
  logic [SW-1:0] starve_q;

  logic in_idle, arb_en, force_st, ld_grant, st_grant, drain_fire, resp_fire, kill_now;

  // Arbitration: forced stores, then loads (unless fencing), then stores.
  always_comb begin
    in_idle    = (state_q == IDLE);
    arb_en     = in_idle && !flush && !reset;
    force_st   = drain_pending_q || sb_full || (starve_q >= STARVE_MAX);
    ld_grant   = arb_en && ld_req_valid && !drain_pending_q && !(force_st && sb_deq_valid);
    st_grant   = arb_en && sb_deq_valid && !ld_grant;
    drain_fire = drain_pending_q && in_idle && (sb_count == CW'(0)) && !flush;
    resp_fire  = (state_q == RESP) && dc_resp_valid;
    kill_now   = kill_q || flush;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld_grant || st_grant) state_d = REQ;
      REQ:     if (dc_req_ready)         state_d = RESP;
      RESP:    if (dc_resp_valid)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_ready      = 1'b0;
    ld_resp_valid = 1'b0;
    ld_resp_data  = 32'd0;
    sb_deq_req    = 1'b0;
    drain_done    = 1'b0;
    dc_req_valid  = (state_q == REQ);
    dc_req_we     = we_q;
    dc_req_addr   = addr_q;
    dc_req_wdata  = wdata_q;
    dc_req_wstrb  = wstrb_q;
    ld_ready      = ld_grant;
    drain_done    = drain_fire;
    if (resp_fire && !kill_now) begin
      if (we_q) begin
        sb_deq_req = 1'b1;
      end else begin
        ld_resp_valid = 1'b1;
        ld_resp_data  = dc_resp_rdata;
      end
    end
  end

  // Request registers hold the granted transaction until the cache consumes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else if (st_grant) begin
      we_q    <= 1'b1;
      addr_q  <= sb_deq_addr;
      wdata_q <= sb_deq_data;
      wstrb_q <= sb_deq_wstrb;
    end else if (ld_grant) begin
      we_q    <= 1'b0;
      addr_q  <= ld_addr;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end
  end

  // Fence, starvation and kill bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drain_pending_q <= 1'b0;
      starve_q        <= '0;
      kill_q          <= 1'b0;
    end else begin
      if (flush)           drain_pending_q <= 1'b0;
      else if (drain_fire) drain_pending_q <= 1'b0;
      else if (drain_all)  drain_pending_q <= 1'b1;

      if (flush || !sb_deq_valid || st_grant)    starve_q <= '0;
      else if (ld_grant && starve_q != STARVE_MAX) starve_q <= starve_q + SW'(1);

      if (resp_fire)             kill_q <= 1'b0;
      else if (flush && !in_idle) kill_q <= 1'b1;
    end
  end

endmodule
